// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit: owns the PC, issues credit-limited in-order imem fetches,
// buffers returned words and flushes on redirect. Define IFU_PERF_EN for perf counters.
module ysyx_220053_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   fetch_pc, fetch_pc_n;
    logic          req_valid_n, req_stale, req_stale_n;
    logic [31:0]   req_addr_n;
    logic [CW-1:0] outs, outs_n, drop, drop_n, cnt, cnt_n;
    logic [PW-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n, pq_wr, pq_rd;
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   pq_mem   [DEPTH];
    logic          accept, rsp_trk, push, pop, load;
    logic          head_valid_n;
    logic [31:0]   head_instr_n, head_pc_n;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // Next-state: credit accounting, drop tracking, request issue and buffer head.
    always_comb begin
        accept      = imem_req_valid && imem_req_ready;
        rsp_trk     = imem_rsp_valid && (outs != '0);
        push        = rsp_trk && !redirect_valid && (drop == '0);
        pop         = instr_valid && instr_ready;
        outs_n      = outs + CW'(accept) - CW'(rsp_trk);
        drop_n      = drop + CW'(accept && req_stale) - CW'(rsp_trk && (drop != '0));
        cnt_n       = cnt + CW'(push) - CW'(pop);
        wr_ptr_n    = push ? ptr_inc(wr_ptr) : wr_ptr;
        rd_ptr_n    = pop ? ptr_inc(rd_ptr) : rd_ptr;
        req_stale_n = req_stale && !accept;
        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path.
            drop_n      = outs_n;
            cnt_n       = '0;
            wr_ptr_n    = '0;
            rd_ptr_n    = '0;
            req_stale_n = imem_req_valid && !accept;
        end

        load = !redirect_valid && (!imem_req_valid || accept)
            && (32'(cnt_n) + 32'(outs_n) < DEPTH);
        req_valid_n = load || (imem_req_valid && !accept);
        req_addr_n  = load ? fetch_pc : imem_req_addr;

        fetch_pc_n = fetch_pc;
        if (redirect_valid)
            fetch_pc_n = redirect_pc & ~32'd3;
        else if (load)
            fetch_pc_n = fetch_pc + 32'd4;

        head_valid_n = (cnt_n != '0);
        head_instr_n = instr_o;
        head_pc_n    = pc_o;
        if (head_valid_n) begin
            if (push && (wr_ptr == rd_ptr_n)) begin
                head_instr_n = imem_rsp_data;
                head_pc_n    = pq_mem[pq_rd];
            end else begin
                head_instr_n = data_mem[rd_ptr_n];
                head_pc_n    = pc_mem[rd_ptr_n];
            end
        end
    end

    // Buffer and per-request PC queue storage.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= pq_mem[pq_rd];
        end
        if (accept)
            pq_mem[pq_wr] <= imem_req_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc       <= RESET_PC;
            imem_req_valid <= 1'b0;
            imem_req_addr  <= RESET_PC;
            req_stale      <= 1'b0;
            outs           <= '0;
            drop           <= '0;
            cnt            <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            pq_wr          <= '0;
            pq_rd          <= '0;
            instr_valid    <= 1'b0;
            instr_o        <= '0;
            pc_o           <= '0;
        end else begin
            fetch_pc       <= fetch_pc_n;
            imem_req_valid <= req_valid_n;
            imem_req_addr  <= req_addr_n;
            req_stale      <= req_stale_n;
            outs           <= outs_n;
            drop           <= drop_n;
            cnt            <= cnt_n;
            wr_ptr         <= wr_ptr_n;
            rd_ptr         <= rd_ptr_n;
            if (accept)
                pq_wr <= ptr_inc(pq_wr);
            if (rsp_trk)
                pq_rd <= ptr_inc(pq_rd);
            instr_valid    <= head_valid_n;
            instr_o        <= head_instr_n;
            pc_o           <= head_pc_n;
        end
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (pop)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (redirect_valid)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (instr_ready && !instr_valid)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Directed bench for ysyx_220053_ifu: latency-programmable memory model, delivery
// logger and hand-computed expectations; perf counters checked when IFU_PERF_EN is set.
`timescale 1ns/1ps
module tb_ysyx_220053_ifu;
    logic        clk, rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_o, pc_o;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf_stall_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int lat = 1;
    int ncyc = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] got_pc[$], got_instr[$], acc_addr[$];

    ysyx_220053_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory returns ~addr 'lat' cycles after acceptance; also logs handshakes.
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (!rst_n) begin
            mq_addr.delete();
            mq_due.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else begin
            if (instr_valid && instr_ready) begin
                got_pc.push_back(pc_o);
                got_instr.push_back(instr_o);
            end
            if (imem_req_valid && imem_req_ready) begin
                acc_addr.push_back(imem_req_addr);
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(ncyc + lat);
            end
            imem_rsp_valid = 1'b0;
            if (mq_due.size() > 0 && mq_due[0] == ncyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~mq_addr[0];
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        got_pc.delete();
        got_instr.delete();
        acc_addr.delete();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (3) tick();
    endtask

    int fetched, stalls, redir;

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        // 1: reset values, then streaming fetch with single-cycle memory
        do_reset();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_o", instr_o, 32'd0);
        check("rst_pc_o", pc_o, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h8000_0000);
        clear_logs();
        lat = 1;
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        tick();
        check("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
        check("t1_first_req_addr", imem_req_addr, 32'h8000_0000);
        tick();
        check("t1_no_bypass", 32'(instr_valid), 32'd0);
        tick();
        check("t1_first_instr_valid", 32'(instr_valid), 32'd1);
        check("t1_first_pc", pc_o, 32'h8000_0000);
        check("t1_first_instr", instr_o, 32'h7fff_ffff);
        repeat (20) tick();
        check("t1_delivered_ge5", 32'(got_pc.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("t1_req_addr", acc_addr[i], 32'h8000_0000 + 32'(4 * i));
            check("t1_pc", got_pc[i], 32'h8000_0000 + 32'(4 * i));
            check("t1_instr", got_instr[i], ~(32'h8000_0000 + 32'(4 * i)));
        end

        // 2: decoder stalled -> exactly DEPTH requests, then order preserved
        do_reset();
        clear_logs();
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        repeat (10) tick();
        check("t2_accepted", 32'(acc_addr.size()), 32'd2);
        check("t2_req_idle", 32'(imem_req_valid), 32'd0);
        check("t2_head_valid", 32'(instr_valid), 32'd1);
        check("t2_head_pc", pc_o, 32'h8000_0000);
        instr_ready = 1'b1;
        repeat (15) tick();
        for (int i = 0; i < 4; i++)
            check("t2_pc", got_pc[i], 32'h8000_0000 + 32'(4 * i));

        // 3: 3-cycle memory, redirect with two outstanding
        do_reset();
        clear_logs();
        lat = 3;
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        repeat (3) tick();
        check("t3_outstanding", 32'(acc_addr.size()), 32'd2);
        check("t3_req_idle", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0103;
        tick();
        redirect_valid = 1'b0;
        check("t3_flush_valid", 32'(instr_valid), 32'd0);
        clear_logs();
        repeat (20) tick();
        check("t3_next_req", acc_addr[0], 32'h8000_0100);
        check("t3_next_pc", got_pc[0], 32'h8000_0100);
        check("t3_next_instr", got_instr[0], ~32'h8000_0100);
        check("t3_second_pc", got_pc[1], 32'h8000_0104);

        // 4: redirect while a request is held by imem_req_ready=0
        do_reset();
        clear_logs();
        lat = 1;
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        repeat (3) tick();
        imem_req_ready = 1'b0;
        tick();
        check("t4_pending_valid", 32'(imem_req_valid), 32'd1);
        check("t4_pending_addr", imem_req_addr, 32'h8000_0008);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        check("t4_flush_valid", 32'(instr_valid), 32'd0);
        check("t4_hold_addr", imem_req_addr, 32'h8000_0008);
        clear_logs();
        repeat (2) tick();
        check("t4_hold_valid", 32'(imem_req_valid), 32'd1);
        check("t4_hold_addr2", imem_req_addr, 32'h8000_0008);
        imem_req_ready = 1'b1;
        tick();
        check("t4_target_req", imem_req_addr, 32'h8000_0200);
        repeat (15) tick();
        check("t4_acc0", acc_addr[0], 32'h8000_0008);
        check("t4_acc1", acc_addr[1], 32'h8000_0200);
        check("t4_first_pc", got_pc[0], 32'h8000_0200);

        // 5: response coincident with redirect, then reset mid-stream
        do_reset();
        clear_logs();
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        check("t5_drop_valid", 32'(instr_valid), 32'd0);
        clear_logs();
        repeat (12) tick();
        check("t5_first_req", acc_addr[0], 32'h8000_0300);
        check("t5_first_pc", got_pc[0], 32'h8000_0300);
        rst_n = 1'b0;
        repeat (2) tick();
        check("t5_rst_instr_valid", 32'(instr_valid), 32'd0);
        check("t5_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("t5_rst_addr", imem_req_addr, 32'h8000_0000);
        rst_n = 1'b1;
        tick();
        check("t5_restart_valid", 32'(imem_req_valid), 32'd1);
        check("t5_restart_addr", imem_req_addr, 32'h8000_0000);
        check("t5_restart_instr_valid", 32'(instr_valid), 32'd0);

`ifdef IFU_PERF_EN
        // 6: 5 fetches, 1 redirect, 3 starved cycles
        do_reset();
        check("t6_rst_fetch", perf_fetch_cnt, 32'd0);
        check("t6_rst_flush", perf_flush_cnt, 32'd0);
        check("t6_rst_stall", perf_stall_cnt, 32'd0);
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        fetched = 0;
        stalls = 0;
        redir = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            redirect_valid = 1'b0;
            if (fetched == 5)
                break;
            if (fetched == 2 && redir == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = 32'h8000_0400;
                instr_ready = 1'b0;
                redir = 1;
            end else if (instr_valid) begin
                instr_ready = 1'b1;
                fetched++;
            end else if (stalls < 3) begin
                instr_ready = 1'b1;
                stalls++;
            end else begin
                instr_ready = 1'b0;
            end
        end
        instr_ready = 1'b0;
        check("t6_scenario_done", 32'(fetched), 32'd5);
        check("t6_fetch_cnt", perf_fetch_cnt, 32'd5);
        check("t6_flush_cnt", perf_flush_cnt, 32'd1);
        check("t6_stall_cnt", perf_stall_cnt, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
